wb_pipelined_reg_slice: RTL and testbench

//  Register slice for a pipelined Wishbone link, placed directly downstream of the

---
 rtl/wb_pipelined_reg_slice.sv | 179 +++++++++++++++++
 tb/tb_wb_pipelined_reg_slice.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_pipelined_reg_slice.sv
// -----------------------------------------------------------------------------
// wb_pipelined_reg_slice
//
// Register slice for a pipelined Wishbone link. It sits between an upstream
// master (the sl_* side) and a downstream pipelined slave (the ma_* side).
// It breaks the combinational paths on stb, stall and ack:
//   - requests pass through an output register backed by a one-entry skid
//     register, so the upstream stall depends on flops only;
//   - responses are registered on the way back;
//   - a 4-bit counter limits the number of requests issued downstream but not
//     yet answered to g_max_outstanding;
//   - dropping sl_cyc_i aborts the cycle: buffers are flushed, the counter is
//     cleared and late responses are discarded.
//
// Ports
//   clk_i, rst_i                      clock, synchronous active-high reset
//   sl_adr_i/dat_i/sel_i/we_i         upstream request fields
//   sl_cyc_i, sl_stb_i                upstream cycle / strobe
//   sl_stall_o                        upstream stall (from registers only)
//   sl_ack_o/err_o/rty_o, sl_dat_o    registered responses and read data
//   ma_adr_o/dat_o/sel_o/we_o         registered downstream request fields
//   ma_cyc_o, ma_stb_o                registered downstream cycle / strobe
//   ma_stall_i                        downstream stall
//   ma_ack_i/err_i/rty_i, ma_dat_i    downstream responses and read data
// -----------------------------------------------------------------------------
module wb_pipelined_reg_slice #(
    parameter int g_adr_width       = 32,
    parameter int g_dat_width       = 32,
    parameter int g_max_outstanding = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    // upstream (slave) port
    input  logic [g_adr_width-1:0]   sl_adr_i,
    input  logic [g_dat_width-1:0]   sl_dat_i,
    input  logic [g_dat_width/8-1:0] sl_sel_i,
    input  logic                     sl_we_i,
    input  logic                     sl_cyc_i,
    input  logic                     sl_stb_i,
    output logic                     sl_stall_o,
    output logic                     sl_ack_o,
    output logic                     sl_err_o,
    output logic                     sl_rty_o,
    output logic [g_dat_width-1:0]   sl_dat_o,
    // downstream (master) port
    output logic [g_adr_width-1:0]   ma_adr_o,
    output logic [g_dat_width-1:0]   ma_dat_o,
    output logic [g_dat_width/8-1:0] ma_sel_o,
    output logic                     ma_we_o,
    output logic                     ma_cyc_o,
    output logic                     ma_stb_o,
    input  logic                     ma_stall_i,
    input  logic                     ma_ack_i,
    input  logic                     ma_err_i,
    input  logic                     ma_rty_i,
    input  logic [g_dat_width-1:0]   ma_dat_i
);

    localparam int SW = g_dat_width / 8;
    // packed request: {we, sel, dat, adr}
    localparam int RW = g_adr_width + g_dat_width + SW + 1;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic               out_valid_q, out_valid_d;
    logic [RW-1:0]      out_req_q, out_req_d;
    logic               skid_valid_q, skid_valid_d;
    logic [RW-1:0]      skid_req_q, skid_req_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [2:0]         resp_q, resp_d;
    logic [g_dat_width-1:0] rdat_q;

    logic [RW-1:0]      sl_req;
    logic [4:0]         credit_sum;
    logic               accept;
    logic               issue;
    logic               resp_valid;

    assign sl_req = {sl_we_i, sl_sel_i, sl_dat_i, sl_adr_i};

    // Requests already issued plus those still buffered count against the
    // credit limit, so the stall never lets more than g_max_outstanding out.
    assign credit_sum = {1'b0, cnt_q} + {4'b0, out_valid_q} + {4'b0, skid_valid_q};
    assign sl_stall_o = skid_valid_q | (credit_sum >= 5'(g_max_outstanding));

    assign accept = sl_cyc_i & sl_stb_i & ~sl_stall_o;
    assign issue  = out_valid_q & ~ma_stall_i;

    // A response with nothing outstanding is spurious and ignored entirely.
    assign resp_valid = (ma_ack_i | ma_err_i | ma_rty_i) & ma_cyc_o & (cnt_q != 4'd0);

    // ---------------------------------------------------------------- FSM
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (sl_cyc_i)  state_d = ST_ACTIVE;
            ST_ACTIVE: if (!sl_cyc_i) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // ---------------------------------------------------------- datapath
    always_comb begin
        out_valid_d  = out_valid_q;
        out_req_d    = out_req_q;
        skid_valid_d = skid_valid_q;
        skid_req_d   = skid_req_q;
        cnt_d        = cnt_q;
        resp_d       = {ma_rty_i, ma_err_i, ma_ack_i} & {3{resp_valid & sl_cyc_i}};

        if (!sl_cyc_i) begin
            // cycle end or abort: drop everything buffered or in flight
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
            cnt_d        = 4'd0;
        end else begin
            if (!out_valid_q || issue) begin
                // output register frees up: refill from skid first to keep order
                if (skid_valid_q) begin
                    out_valid_d  = 1'b1;
                    out_req_d    = skid_req_q;
                    skid_valid_d = 1'b0;
                end else begin
                    out_valid_d = accept;
                    if (accept) out_req_d = sl_req;
                end
            end else if (accept) begin
                // output held by ma_stall_i; the skid is empty or we'd be stalled
                skid_valid_d = 1'b1;
                skid_req_d   = sl_req;
            end

            if (issue && !resp_valid)
                cnt_d = 4'(cnt_q + 4'd1);
            else if (!issue && resp_valid)
                cnt_d = 4'(cnt_q - 4'd1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            out_valid_q  <= 1'b0;
            out_req_q    <= '0;
            skid_valid_q <= 1'b0;
            skid_req_q   <= '0;
            cnt_q        <= 4'd0;
            resp_q       <= 3'b000;
            rdat_q       <= '0;
        end else begin
            state_q      <= state_d;
            out_valid_q  <= out_valid_d;
            out_req_q    <= out_req_d;
            skid_valid_q <= skid_valid_d;
            skid_req_q   <= skid_req_d;
            cnt_q        <= cnt_d;
            resp_q       <= resp_d;
            rdat_q       <= ma_dat_i;
        end
    end

    // ----------------------------------------------------------- outputs
    assign ma_cyc_o = (state_q == ST_ACTIVE);
    assign ma_stb_o = out_valid_q;
    assign ma_adr_o = out_req_q[g_adr_width-1:0];
    assign ma_dat_o = out_req_q[g_adr_width+g_dat_width-1:g_adr_width];
    assign ma_sel_o = out_req_q[g_adr_width+g_dat_width+SW-1:g_adr_width+g_dat_width];
    assign ma_we_o  = out_req_q[RW-1];

    assign sl_ack_o = resp_q[0];
    assign sl_err_o = resp_q[1];
    assign sl_rty_o = resp_q[2];
    assign sl_dat_o = rdat_q;

endmodule

// File: tb/tb_wb_pipelined_reg_slice.sv
// -----------------------------------------------------------------------------
// Testbench for wb_pipelined_reg_slice. Accepted requests are pushed to a
// scoreboard queue; a monitor pops and compares each request as it is issued
// downstream. Scenario tasks check latency, stall, credit, abort and response
// behaviour. An optional auto-ack slave answers each issue one cycle later.
// -----------------------------------------------------------------------------
module tb_wb_pipelined_reg_slice;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic [AW-1:0] sl_adr_i;
    logic [DW-1:0] sl_dat_i;
    logic [SW-1:0] sl_sel_i;
    logic          sl_we_i, sl_cyc_i, sl_stb_i;
    logic          sl_stall_o, sl_ack_o, sl_err_o, sl_rty_o;
    logic [DW-1:0] sl_dat_o;
    logic [AW-1:0] ma_adr_o;
    logic [DW-1:0] ma_dat_o;
    logic [SW-1:0] ma_sel_o;
    logic          ma_we_o, ma_cyc_o, ma_stb_o;
    logic          ma_stall_i, ma_ack_i, ma_err_i, ma_rty_i;
    logic [DW-1:0] ma_dat_i;

    always #5 clk_i = ~clk_i;

    wb_pipelined_reg_slice #(
        .g_adr_width(AW), .g_dat_width(DW), .g_max_outstanding(4)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .sl_adr_i(sl_adr_i), .sl_dat_i(sl_dat_i), .sl_sel_i(sl_sel_i), .sl_we_i(sl_we_i),
        .sl_cyc_i(sl_cyc_i), .sl_stb_i(sl_stb_i), .sl_stall_o(sl_stall_o),
        .sl_ack_o(sl_ack_o), .sl_err_o(sl_err_o), .sl_rty_o(sl_rty_o), .sl_dat_o(sl_dat_o),
        .ma_adr_o(ma_adr_o), .ma_dat_o(ma_dat_o), .ma_sel_o(ma_sel_o), .ma_we_o(ma_we_o),
        .ma_cyc_o(ma_cyc_o), .ma_stb_o(ma_stb_o), .ma_stall_i(ma_stall_i),
        .ma_ack_i(ma_ack_i), .ma_err_i(ma_err_i), .ma_rty_i(ma_rty_i), .ma_dat_i(ma_dat_i)
    );

    typedef struct packed {
        logic [AW-1:0] adr;
        logic [DW-1:0] dat;
        logic [SW-1:0] sel;
        logic          we;
    } req_t;

    req_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   n_issue = 0;
    int   n_ack = 0;
    bit   auto_ack = 1'b0;
    bit   issue_flag = 1'b0;

    // Monitor: issues happen on the next rising edge; compare against scoreboard.
    always @(negedge clk_i) begin
        req_t e;
        issue_flag = ma_stb_o & ~ma_stall_i & ~rst_i;
        if (sl_ack_o === 1'b1) n_ack++;
        if (issue_flag) begin
            n_issue++;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL issue_order: unexpected request adr=%h, required no request", ma_adr_o);
            end else begin
                e = exp_q.pop_front();
                if ({ma_adr_o, ma_dat_o, ma_sel_o, ma_we_o} !== e) begin
                    n_err++;
                    $display("FAIL issue_order: got adr=%h dat=%h sel=%h we=%b, required adr=%h dat=%h sel=%h we=%b",
                             ma_adr_o, ma_dat_o, ma_sel_o, ma_we_o, e.adr, e.dat, e.sel, e.we);
                end
            end
        end
    end

    // Auto-ack slave: answer each issue during the following cycle.
    always @(posedge clk_i) begin
        if (auto_ack) begin
            #1;
            ma_ack_i = issue_flag;
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Present a request for this cycle; record it if the slice will take it.
    task automatic offer(input logic [AW-1:0] adr, input logic we, input logic [DW-1:0] dat,
                         output bit acc);
        req_t e;
        sl_stb_i = 1'b1;
        sl_adr_i = adr;
        sl_we_i  = we;
        sl_dat_i = dat;
        sl_sel_i = 4'hF;
        acc = sl_cyc_i & ~sl_stall_o;
        if (acc) begin
            e.adr = adr; e.dat = dat; e.sel = 4'hF; e.we = we;
            exp_q.push_back(e);
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        sl_cyc_i = 0; sl_stb_i = 0; sl_adr_i = 0; sl_dat_i = 0; sl_sel_i = 0; sl_we_i = 0;
        ma_stall_i = 0; ma_ack_i = 0; ma_err_i = 0; ma_rty_i = 0; ma_dat_i = 0;
        for (int c = 0; c < 2; c++) begin
            tick();
            n_cmp++;
            if ({sl_stall_o, sl_ack_o, sl_err_o, sl_rty_o, sl_dat_o, ma_adr_o, ma_dat_o,
                 ma_sel_o, ma_we_o, ma_cyc_o, ma_stb_o} !== '0) begin
                n_err++;
                $display("FAIL reset_outputs: cycle %0d outputs not all zero (stall=%b cyc=%b stb=%b adr=%h), required 0",
                         c, sl_stall_o, ma_cyc_o, ma_stb_o, ma_adr_o);
            end
        end
        rst_i = 1'b0;
        tick();
        n_cmp++;
        if ({sl_stall_o, ma_cyc_o} !== 2'b00) begin
            n_err++;
            $display("FAIL reset_release: stall=%b cyc=%b, required 0 0", sl_stall_o, ma_cyc_o);
        end
        $display("test_reset done");
    endtask

    task automatic test_back_to_back();
        int a0, k0;
        bit acc;
        auto_ack = 1'b1;
        sl_cyc_i = 1'b1;
        a0 = n_issue; k0 = n_ack;
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (sl_stall_o !== 1'b0) begin
                n_err++;
                $display("FAIL b2b_stall: write %0d stall=%b, required 0", i, sl_stall_o);
            end
            offer(32'(i * 4), 1'b1, 32'hA000_0000 + 32'(i), acc);
            tick();
            if (i == 0) begin
                n_cmp++;
                if ({ma_cyc_o, ma_stb_o, ma_adr_o} !== {1'b1, 1'b1, 32'h0}) begin
                    n_err++;
                    $display("FAIL b2b_latency: cyc=%b stb=%b adr=%h, required 1 1 00000000",
                             ma_cyc_o, ma_stb_o, ma_adr_o);
                end
            end
        end
        sl_stb_i = 1'b0;
        repeat (4) tick();
        n_cmp++;
        if ((n_issue - a0) != 8 || (n_ack - k0) != 8 || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL b2b_counts: issued=%0d acks=%0d left=%0d, required 8 8 0",
                     n_issue - a0, n_ack - k0, exp_q.size());
        end
        n_cmp++;
        if ({ma_cyc_o, ma_stb_o} !== 2'b10) begin
            n_err++;
            $display("FAIL b2b_hold_active: cyc=%b stb=%b, required 1 0", ma_cyc_o, ma_stb_o);
        end
        sl_cyc_i = 1'b0;
        tick();
        auto_ack = 1'b0;
        n_cmp++;
        if (ma_cyc_o !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_end: cyc=%b, required 0", ma_cyc_o);
        end
        $display("test_back_to_back done");
    endtask

    task automatic test_stall();
        int a0, idx, nacc, guard;
        bit acc;
        auto_ack = 1'b1;
        sl_cyc_i = 1'b1;
        ma_stall_i = 1'b1;
        a0 = n_issue; idx = 0; nacc = 0;
        for (int k = 0; k < 5; k++) begin
            offer(32'h100 + 32'(idx * 4), 1'b1, 32'hB000_0000 + 32'(idx), acc);
            if (acc) begin idx++; nacc++; end
            tick();
            n_cmp++;
            if ({ma_stb_o, ma_adr_o} !== {1'b1, 32'h100}) begin
                n_err++;
                $display("FAIL stall_hold: cycle %0d stb=%b adr=%h, required 1 00000100", k, ma_stb_o, ma_adr_o);
            end
        end
        n_cmp++;
        if (nacc != 2 || sl_stall_o !== 1'b1) begin
            n_err++;
            $display("FAIL stall_accept: accepted=%0d stall=%b, required 2 1", nacc, sl_stall_o);
        end
        ma_stall_i = 1'b0;
        guard = 0;
        while (idx < 6 && guard < 30) begin
            offer(32'h100 + 32'(idx * 4), 1'b1, 32'hB000_0000 + 32'(idx), acc);
            if (acc) idx++;
            tick();
            guard++;
        end
        sl_stb_i = 1'b0;
        repeat (5) tick();
        n_cmp++;
        if ((n_issue - a0) != 6 || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL stall_drain: issued=%0d left=%0d, required 6 0", n_issue - a0, exp_q.size());
        end
        sl_cyc_i = 1'b0;
        tick();
        auto_ack = 1'b0;
        $display("test_stall done");
    endtask

    task automatic test_credit();
        int a0, idx, nacc;
        bit acc;
        sl_cyc_i = 1'b1;
        a0 = n_issue; idx = 0; nacc = 0;
        for (int k = 0; k < 10; k++) begin
            offer(32'h200 + 32'(idx * 4), 1'b0, 32'h0, acc);
            if (acc) begin idx++; nacc++; end
            tick();
        end
        n_cmp++;
        if (nacc != 4 || (n_issue - a0) != 4 || sl_stall_o !== 1'b1) begin
            n_err++;
            $display("FAIL credit_limit: accepted=%0d issued=%0d stall=%b, required 4 4 1",
                     nacc, n_issue - a0, sl_stall_o);
        end
        ma_ack_i = 1'b1;
        offer(32'h210, 1'b0, 32'h0, acc);
        tick();
        ma_ack_i = 1'b0;
        n_cmp++;
        if ({sl_ack_o, sl_stall_o} !== 2'b10) begin
            n_err++;
            $display("FAIL credit_ack: ack=%b stall=%b, required 1 0", sl_ack_o, sl_stall_o);
        end
        offer(32'h210, 1'b0, 32'h0, acc);
        tick();
        sl_stb_i = 1'b0;
        n_cmp++;
        if ({acc, ma_stb_o, ma_adr_o} !== {1'b1, 1'b1, 32'h210}) begin
            n_err++;
            $display("FAIL credit_next: accepted=%b stb=%b adr=%h, required 1 1 00000210", acc, ma_stb_o, ma_adr_o);
        end
        tick();
        n_cmp++;
        if ((n_issue - a0) != 5 || sl_stall_o !== 1'b1) begin
            n_err++;
            $display("FAIL credit_refill: issued=%0d stall=%b, required 5 1", n_issue - a0, sl_stall_o);
        end
        sl_cyc_i = 1'b0;
        tick();
        $display("test_credit done");
    endtask

    task automatic test_abort();
        int a0, nacc;
        bit acc;
        sl_cyc_i = 1'b1;
        a0 = n_issue;
        for (int k = 0; k < 4; k++) begin
            if (k == 3) ma_stall_i = 1'b1;
            offer(32'h400 + 32'(k * 4), 1'b1, 32'hC000_0000 + 32'(k), acc);
            tick();
        end
        n_cmp++;
        if ((n_issue - a0) != 2 || sl_stall_o !== 1'b1 || ma_stb_o !== 1'b1) begin
            n_err++;
            $display("FAIL abort_setup: issued=%0d stall=%b stb=%b, required 2 1 1",
                     n_issue - a0, sl_stall_o, ma_stb_o);
        end
        sl_cyc_i = 1'b0;
        sl_stb_i = 1'b0;
        ma_ack_i = 1'b1;
        tick();
        n_cmp++;
        if ({ma_cyc_o, ma_stb_o, sl_ack_o} !== 3'b000) begin
            n_err++;
            $display("FAIL abort_flush: cyc=%b stb=%b ack=%b, required 0 0 0", ma_cyc_o, ma_stb_o, sl_ack_o);
        end
        tick();
        ma_ack_i = 1'b0;
        ma_stall_i = 1'b0;
        n_cmp++;
        if ({sl_ack_o, sl_stall_o} !== 2'b00 || exp_q.size() != 2) begin
            n_err++;
            $display("FAIL abort_late_ack: ack=%b stall=%b flushed=%0d, required 0 0 2",
                     sl_ack_o, sl_stall_o, exp_q.size());
        end
        exp_q.delete();
        // a fresh cycle must get the full credit back
        sl_cyc_i = 1'b1;
        nacc = 0;
        for (int k = 0; k < 8; k++) begin
            offer(32'h500 + 32'(nacc * 4), 1'b0, 32'h0, acc);
            if (acc) nacc++;
            tick();
        end
        sl_stb_i = 1'b0;
        n_cmp++;
        if (nacc != 4) begin
            n_err++;
            $display("FAIL abort_cnt_cleared: accepted=%0d, required 4", nacc);
        end
        sl_cyc_i = 1'b0;
        tick();
        $display("test_abort done");
    endtask

    task automatic test_read();
        bit acc;
        sl_cyc_i = 1'b1;
        offer(32'h300, 1'b0, 32'h0, acc);
        tick();
        sl_stb_i = 1'b0;
        tick();
        ma_ack_i = 1'b1;
        ma_dat_i = 32'hDEADBEEF;
        tick();
        ma_ack_i = 1'b0;
        ma_dat_i = 32'h0;
        n_cmp++;
        if ({sl_ack_o, sl_dat_o} !== {1'b1, 32'hDEADBEEF}) begin
            n_err++;
            $display("FAIL read_data: ack=%b dat=%h, required 1 deadbeef", sl_ack_o, sl_dat_o);
        end
        offer(32'h304, 1'b0, 32'h0, acc);
        tick();
        sl_stb_i = 1'b0;
        tick();
        ma_err_i = 1'b1;
        tick();
        ma_err_i = 1'b0;
        n_cmp++;
        if ({sl_err_o, sl_ack_o, sl_rty_o} !== 3'b100) begin
            n_err++;
            $display("FAIL read_err: err=%b ack=%b rty=%b, required 1 0 0", sl_err_o, sl_ack_o, sl_rty_o);
        end
        ma_ack_i = 1'b1;
        tick();
        ma_ack_i = 1'b0;
        n_cmp++;
        if (sl_ack_o !== 1'b0) begin
            n_err++;
            $display("FAIL read_spurious: ack=%b, required 0", sl_ack_o);
        end
        sl_cyc_i = 1'b0;
        tick();
        $display("test_read done");
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_stall();
        test_credit();
        test_abort();
        test_read();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL final_queue: %0d requests never issued, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

endmodule
